// File: rtl/wb_master_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a classic Wishbone
// master port. Round-robin grant in IDLE, a single outstanding bus cycle in
// BUS, and a one-cycle response to the owning requester in RESP.
module wb_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  // requester 0 (instruction)
  input  logic                    req0_req_i,
  output logic                    req0_gnt_o,
  input  logic                    req0_we_i,
  input  logic [DATA_WIDTH/8-1:0] req0_be_i,
  input  logic [ADDR_WIDTH-1:0]   req0_addr_i,
  input  logic [DATA_WIDTH-1:0]   req0_wdata_i,
  output logic [DATA_WIDTH-1:0]   req0_rdata_o,
  output logic                    req0_rvalid_o,
  output logic                    req0_err_o,
  // requester 1 (data)
  input  logic                    req1_req_i,
  output logic                    req1_gnt_o,
  input  logic                    req1_we_i,
  input  logic [DATA_WIDTH/8-1:0] req1_be_i,
  input  logic [ADDR_WIDTH-1:0]   req1_addr_i,
  input  logic [DATA_WIDTH-1:0]   req1_wdata_i,
  output logic [DATA_WIDTH-1:0]   req1_rdata_o,
  output logic                    req1_rvalid_o,
  output logic                    req1_err_o,
  // Wishbone master
  output logic                    mcyc_o,
  output logic                    mstb_o,
  output logic                    mwe_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic [DATA_WIDTH-1:0]   mdata_o,
  output logic [DATA_WIDTH/8-1:0] msel_o,
  input  logic                    mstall_i,
  input  logic                    mack_i,
  input  logic [DATA_WIDTH-1:0]   mdata_i,
  input  logic                    merr_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  // Counter value in the last permitted BUS cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic                    we_q, we_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                    pick;

  // Stall needs no handling of its own: BUS simply waits for ack/err.
  logic stall_unused;
  assign stall_unused = mstall_i;

  // Next-state, arbitration, field capture and response capture.
  always_comb begin
    // NOTE: every signal driven here gets its default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    req0_gnt_o = 1'b0;
    req1_gnt_o = 1'b0;
    // Tie goes to the requester not granted last; a sole requester always wins.
    pick       = (req0_req_i && req1_req_i) ? ~last_q : req1_req_i;

    unique case (state_q)
      ST_IDLE: begin
        if (!reset_i && (req0_req_i || req1_req_i)) begin
          req0_gnt_o = ~pick;
          req1_gnt_o = pick;
          owner_d    = pick;
          last_d     = pick;
          we_d       = pick ? req1_we_i    : req0_we_i;
          be_d       = pick ? req1_be_i    : req0_be_i;
          addr_d     = pick ? req1_addr_i  : req0_addr_i;
          wdata_d    = pick ? req1_wdata_i : req0_wdata_i;
          cnt_d      = 8'd0;
          err_d      = 1'b0;
          state_d    = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (mack_i || merr_i) begin
          // Ack together with err counts as an error.
          err_d   = merr_i;
          state_d = ST_RESP;
          if (owner_q) rdata1_d = (merr_i || we_q) ? '0 : mdata_i;
          else         rdata0_d = (merr_i || we_q) ? '0 : mdata_i;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before this edge, independent of statement order.
    if (reset_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mcyc_o        = (state_q == ST_BUS);
  assign mstb_o        = (state_q == ST_BUS);
  assign mwe_o         = we_q;
  assign maddr_o       = addr_q;
  assign mdata_o       = wdata_q;
  assign msel_o        = be_q;

  assign req0_rvalid_o = (state_q == ST_RESP) && !owner_q;
  assign req1_rvalid_o = (state_q == ST_RESP) &&  owner_q;
  assign req0_err_o    = req0_rvalid_o && err_q;
  assign req1_err_o    = req1_rvalid_o && err_q;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: a table of transactions run through one task,
// a scoreboard of expected responses checked whenever rvalid appears, and
// hand sequences for spurious ack and reset in the middle of a bus cycle.
module tb_wb_master_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 8;
  localparam int NV  = 10;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req0_req_i, req0_gnt_o, req0_we_i, req0_rvalid_o, req0_err_o;
  logic [BW-1:0] req0_be_i;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_wdata_i, req0_rdata_o;
  logic          req1_req_i, req1_gnt_o, req1_we_i, req1_rvalid_o, req1_err_o;
  logic [BW-1:0] req1_be_i;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_wdata_i, req1_rdata_o;
  logic          mcyc_o, mstb_o, mwe_o, mstall_i, mack_i, merr_i;
  logic [AW-1:0] maddr_o;
  logic [DW-1:0] mdata_o, mdata_i;
  logic [BW-1:0] msel_o;

  always #5 clk_i = ~clk_i;

  wb_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_req_i(req0_req_i), .req0_gnt_o(req0_gnt_o), .req0_we_i(req0_we_i),
    .req0_be_i(req0_be_i), .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .req0_rdata_o(req0_rdata_o), .req0_rvalid_o(req0_rvalid_o), .req0_err_o(req0_err_o),
    .req1_req_i(req1_req_i), .req1_gnt_o(req1_gnt_o), .req1_we_i(req1_we_i),
    .req1_be_i(req1_be_i), .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .req1_rdata_o(req1_rdata_o), .req1_rvalid_o(req1_rvalid_o), .req1_err_o(req1_err_o),
    .mcyc_o(mcyc_o), .mstb_o(mstb_o), .mwe_o(mwe_o), .maddr_o(maddr_o),
    .mdata_o(mdata_o), .msel_o(msel_o), .mstall_i(mstall_i), .mack_i(mack_i),
    .mdata_i(mdata_i), .merr_i(merr_i)
  );

  typedef struct {
    logic        req0, req1, hold;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    int          n_wait;
    logic        stall, tmo, ack, err;
    logic [31:0] mdata;
    logic        exp_owner, exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  vec_t  vecs [NV];
  resp_t sb_q [$];
  resp_t mon_r;
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, r1, hold, we, input logic [3:0] be,
                              input logic [31:0] addr, wdata, input int n_wait,
                              input logic stall, tmo, ack, err, input logic [31:0] mdata,
                              input logic owner, exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.hold = hold; v.we = we; v.be = be;
    v.addr = addr; v.wdata = wdata; v.n_wait = n_wait; v.stall = stall;
    v.tmo = tmo; v.ack = ack; v.err = err; v.mdata = mdata;
    v.exp_owner = owner; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Winner's inputs carry the vector fields, the loser's carry their complement.
  task automatic drive_reqs(input vec_t v);
    req0_req_i = v.req0;
    req1_req_i = v.req1;
    req0_we_i    = v.exp_owner ? ~v.we    : v.we;
    req0_be_i    = v.exp_owner ? ~v.be    : v.be;
    req0_addr_i  = v.exp_owner ? ~v.addr  : v.addr;
    req0_wdata_i = v.exp_owner ? ~v.wdata : v.wdata;
    req1_we_i    = v.exp_owner ? v.we     : ~v.we;
    req1_be_i    = v.exp_owner ? v.be     : ~v.be;
    req1_addr_i  = v.exp_owner ? v.addr   : ~v.addr;
    req1_wdata_i = v.exp_owner ? v.wdata  : ~v.wdata;
  endtask

  // Requester inputs after the grant must have no effect.
  task automatic scramble(input logic hold);
    req0_req_i   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    req1_req_i   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    req0_we_i    = 1'($urandom_range(0, 1));
    req1_we_i    = 1'($urandom_range(0, 1));
    req0_be_i    = 4'($urandom);
    req1_be_i    = 4'($urandom);
    req0_addr_i  = $urandom;
    req1_addr_i  = $urandom;
    req0_wdata_i = $urandom;
    req1_wdata_i = $urandom;
  endtask

  task automatic check_bus(input vec_t v);
    check("bus_mcyc",  32'(mcyc_o), 32'd1);
    check("bus_mstb",  32'(mstb_o), 32'd1);
    check("bus_mwe",   32'(mwe_o),  32'(v.we));
    check("bus_maddr", maddr_o,     v.addr);
    check("bus_mdata", mdata_o,     v.wdata);
    check("bus_msel",  32'(msel_o), 32'(v.be));
    check("bus_gnt",   32'({req1_gnt_o, req0_gnt_o}), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    drive_reqs(v);
    #1;
    check("gnt0", 32'(req0_gnt_o), 32'(v.exp_owner == 1'b0));
    check("gnt1", 32'(req1_gnt_o), 32'(v.exp_owner == 1'b1));
    sb_q.push_back('{owner: v.exp_owner, err: v.exp_err, rdata: v.exp_rdata});
    step();
    scramble(v.hold);
    for (int i = 0; i < v.n_wait; i++) begin
      mstall_i = v.stall; mack_i = 1'b0; merr_i = 1'b0; mdata_i = $urandom;
      #1;
      check_bus(v);
      step();
    end
    if (!v.tmo) begin
      mstall_i = 1'b0; mack_i = v.ack; merr_i = v.err; mdata_i = v.mdata;
      #1;
      check_bus(v);
      step();
    end
    mack_i = 1'b0; merr_i = 1'b0; mstall_i = 1'b0;
    req0_req_i = v.hold; req1_req_i = v.hold;
    #1;
    check("resp_mcyc", 32'(mcyc_o), 32'd0);
    check("resp_rvalid", 32'(v.exp_owner ? req1_rvalid_o : req0_rvalid_o), 32'd1);
    check("resp_gnt", 32'({req1_gnt_o, req0_gnt_o}), 32'd0);
    step();
  endtask

  // Scoreboard: every response the DUT presents is matched against the queue.
  always @(negedge clk_i) begin
    if (req0_rvalid_o || req1_rvalid_o) begin
      check("rvalid_onehot", 32'(req0_rvalid_o & req1_rvalid_o), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 32'({req1_rvalid_o, req0_rvalid_o}), 32'd0);
      end else begin
        mon_r = sb_q.pop_front();
        check("sb_owner", 32'(req1_rvalid_o), 32'(mon_r.owner));
        check("sb_err", 32'(mon_r.owner ? req1_err_o : req0_err_o), 32'(mon_r.err));
        check("sb_other_err", 32'(mon_r.owner ? req0_err_o : req1_err_o), 32'd0);
        check("sb_rdata", mon_r.owner ? req1_rdata_o : req0_rdata_o, mon_r.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           r0 r1 hd we be    addr          wdata         nw stl tmo ack err mdata         own eer exp_rdata
    vecs[0] = mk(1, 1, 1, 0, 4'hF, 32'h0000_0100, 32'h0,        0, 0, 0,  1,  0,  32'h1111_1111, 0, 0, 32'h1111_1111);
    vecs[1] = mk(1, 1, 1, 1, 4'hF, 32'h0000_0200, 32'hA5A5_A5A5, 0, 0, 0,  1,  0,  32'h9999_9999, 1, 0, 32'h0);
    vecs[2] = mk(1, 1, 1, 0, 4'hF, 32'h0000_0300, 32'h0,        0, 0, 0,  1,  0,  32'h2222_2222, 0, 0, 32'h2222_2222);
    vecs[3] = mk(1, 1, 1, 0, 4'hF, 32'h0000_0400, 32'h0,        0, 0, 0,  1,  0,  32'h3333_3333, 1, 0, 32'h3333_3333);
    vecs[4] = mk(1, 0, 0, 0, 4'hF, 32'h0000_1000, 32'h0,        1, 0, 0,  1,  0,  32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    vecs[5] = mk(0, 1, 0, 0, 4'hF, 32'h0000_2000, 32'h0,        2, 1, 0,  0,  1,  32'h7777_7777, 1, 1, 32'h0);
    vecs[6] = mk(1, 0, 0, 1, 4'h3, 32'h0000_3000, 32'h1234_5678, 4, 1, 0,  1,  1,  32'h8888_8888, 0, 1, 32'h0);
    vecs[7] = mk(1, 1, 0, 0, 4'hF, 32'h0000_4000, 32'h0,        0, 0, 0,  1,  0,  32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D);
    vecs[8] = mk(1, 0, 0, 0, 4'hF, 32'h0000_5000, 32'h0,      TMO, 0, 1,  0,  0,  32'h0,         0, 1, 32'h0);
    vecs[9] = mk(1, 1, 0, 0, 4'hF, 32'h0000_6000, 32'h0,        3, 0, 0,  1,  0,  32'h5A5A_5A5A, 1, 0, 32'h5A5A_5A5A);

    reset_i = 1'b1;
    req0_req_i = 1'b0; req0_we_i = 1'b0; req0_be_i = '0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_req_i = 1'b0; req1_we_i = 1'b0; req1_be_i = '0; req1_addr_i = '0; req1_wdata_i = '0;
    mstall_i = 1'b0; mack_i = 1'b0; merr_i = 1'b0; mdata_i = '0;
    repeat (3) step();
    reset_i = 1'b0;
    #1;
    check("rst_mcyc",   32'(mcyc_o), 32'd0);
    check("rst_gnt",    32'({req1_gnt_o, req0_gnt_o}), 32'd0);
    check("rst_rvalid", 32'({req1_rvalid_o, req0_rvalid_o}), 32'd0);
    check("rst_maddr",  maddr_o, 32'd0);
    check("rst_rdata0", req0_rdata_o, 32'd0);

    for (int i = 0; i < NV; i++) run_txn(vecs[i]);

    // Spurious ack/err while idle: no bus activity, no response, rdata held.
    for (int i = 0; i < 3; i++) begin
      mack_i = 1'b1; merr_i = 1'(i); mdata_i = 32'hFFFF_FFFF;
      #1;
      check("spur_mcyc",   32'(mcyc_o), 32'd0);
      check("spur_rvalid", 32'({req1_rvalid_o, req0_rvalid_o}), 32'd0);
      step();
    end
    mack_i = 1'b0; merr_i = 1'b0;
    #1;
    check("spur_mcyc_after", 32'(mcyc_o), 32'd0);
    check("hold_rdata0", req0_rdata_o, 32'h0);
    check("hold_rdata1", req1_rdata_o, 32'h5A5A_5A5A);

    // Reset at BUS cycle 3 of a requester-0 cycle (pointer would favour 1).
    req0_req_i = 1'b1; req0_addr_i = 32'h0000_8000;
    #1;
    check("mid_gnt0", 32'(req0_gnt_o), 32'd1);
    step();
    req0_req_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("mid_mcyc", 32'(mcyc_o), 32'd1);
      if (i == 3) reset_i = 1'b1;
      step();
    end
    reset_i = 1'b0;
    #1;
    check("mid_rst_mcyc",   32'(mcyc_o), 32'd0);
    check("mid_rst_maddr",  maddr_o, 32'd0);
    check("mid_rst_rvalid", 32'({req1_rvalid_o, req0_rvalid_o}), 32'd0);
    check("mid_rst_rdata1", req1_rdata_o, 32'd0);
    repeat (2) step();
    check("mid_idle_mcyc", 32'(mcyc_o), 32'd0);
    run_txn(mk(1, 1, 0, 0, 4'hF, 32'h0000_7000, 32'h0, 0, 0, 0, 1, 0,
               32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D));

    repeat (2) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address bus width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1-255: maximum BUS-state cycles before abort.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  clock; reset_i  input  1  synchronous active-high reset.
REQ-005 SHALL have, for each requester n in {0,1} (0 = instruction, 1 = data), Ibex-style ports: reqn_req_i  input  1  request; reqn_gnt_o  output  1  grant; reqn_we_i  input  1  write enable; reqn_be_i  input  DATA_WIDTH/8  byte enables; reqn_addr_i  input  ADDR_WIDTH  address; reqn_wdata_i  input  DATA_WIDTH  write data; reqn_rdata_o  output  DATA_WIDTH  read data; reqn_rvalid_o  output  1  response valid; reqn_err_o  output  1  response error.
REQ-006 SHALL have classic Wishbone master ports: mcyc_o  output  1; mstb_o  output  1; mwe_o  output  1; maddr_o  output  ADDR_WIDTH; mdata_o  output  DATA_WIDTH; msel_o  output  DATA_WIDTH/8; mstall_i  input  1; mack_i  input  1; mdata_i  input  DATA_WIDTH; merr_i  input  1.

Function
REQ-007 SHALL implement FSM states IDLE, BUS, RESP; one Wishbone cycle outstanding at most.
REQ-008 In IDLE, with any reqn_req_i high, SHALL assert exactly one reqn_gnt_o combinationally that cycle, latch that requester's we/be/addr/wdata plus owner index, and move to BUS.
REQ-009 Arbitration SHALL be round-robin: sole requester wins; on simultaneous requests the requester not granted last wins; the last-granted pointer updates on every grant.
REQ-010 reqn_gnt_o SHALL be low in BUS and RESP, and in IDLE when reqn_req_i is low.
REQ-011 In BUS, mcyc_o and mstb_o SHALL be high and mwe_o/maddr_o/mdata_o/msel_o SHALL drive the latched fields, stable for the whole state; mstall_i high only extends BUS.
REQ-012 In BUS, mack_i or merr_i high SHALL move to RESP next cycle; mcyc_o/mstb_o low from that next cycle.
REQ-013 mack_i and merr_i high together SHALL be treated as error.
REQ-014 A cycle counter SHALL clear on BUS entry and increment each BUS cycle; with no ack/err when it equals TIMEOUT_CYCLES-1, the FSM SHALL abort to RESP with error.
REQ-015 In RESP (exactly one cycle), the owner's reqn_rvalid_o SHALL be high; reqn_err_o SHALL be high on error or timeout; reqn_rdata_o SHALL carry mdata_i registered at ack (zero on error, timeout, or write); then IDLE.
REQ-016 Non-owner rvalid/err SHALL stay low; rdata_o of both requesters SHALL hold its last value outside RESP.
REQ-017 Latency: grant at cycle 0, mcyc_o at cycle 1, ack at cycle k>=1, rvalid at k+1, earliest next grant at k+2.
REQ-018 Requester inputs outside the IDLE grant cycle SHALL be ignored; requests dropped before grant SHALL produce no bus activity.
REQ-019 mack_i/merr_i outside BUS SHALL be ignored.

Reset
REQ-020 reset_i high at a clock edge SHALL force IDLE, clear the counter and latched fields, set the last-granted pointer to 1 (requester 0 wins the first tie), and drive all outputs to zero; reset mid-BUS SHALL drop mcyc_o/mstb_o next cycle and return no response.

Verification
REQ-021 Single read: req0 addr 0x1000, ack at bus cycle 2 with mdata_i 0xDEADBEEF -> gnt0 cycle 0, mcyc_o cycles 1-2, rvalid0 cycle 3 with rdata0 0xDEADBEEF, err0 0.
REQ-022 Contention: req0 and req1 held high from reset, immediate acks -> grants alternate 0,1,0,1; no grant during BUS/RESP.
REQ-023 Stall then error: write be 0x3, mstall_i high 4 cycles, then mack_i and merr_i together -> maddr/mdata/msel stable throughout, rvalid with err high, rdata 0.
REQ-024 Timeout: TIMEOUT_CYCLES=8, no ack -> mcyc_o high 8 cycles, then rvalid+err to owner, bus idle.
REQ-025 Reset mid-BUS: reset_i at BUS cycle 3 -> mcyc_o low next cycle, no rvalid, next tie granted to requester 0.
REQ-026 Spurious mack_i in IDLE -> no rvalid, FSM stays IDLE.
